// File: rtl/game_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : game_sequencer
// Description : Top-level game FSM; sequences the timer bank and tracks
//               obstacle phase, lives and game-over status.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module game_sequencer #(
    parameter int NUM_PHASES   = 4,
    parameter int LIVES        = 3,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       collision,
    input  logic       runOver,
    input  logic       changeState,
    input  logic       startCycle,
    input  logic       recover,
    input  logic       explosionDone,
    input  logic       timeUp,
    output logic       CounterClear,
    output logic       CycleWaitCounterEn,
    output logic       ChangeStateCounterEn,
    output logic       ScoreInc,
    output logic       StartRecover,
    output logic [3:0] obstaclePhase,
    output logic [3:0] lives,
    output logic       playing,
    output logic       gameOver
);

    localparam int                c_CW         = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    localparam logic [c_CW-1:0]   c_CLR_LAST   = c_CW'(CLEAR_CYCLES - 1);
    localparam logic [3:0]        c_LIVES      = 4'(LIVES);
    localparam logic [3:0]        c_LAST_PHASE = 4'(NUM_PHASES - 1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_CLEAR   = 3'd1;
    localparam logic [2:0] c_WAIT    = 3'd2;
    localparam logic [2:0] c_STEP    = 3'd3;
    localparam logic [2:0] c_RECOVER = 3'd4;
    localparam logic [2:0] c_EXPLODE = 3'd5;
    localparam logic [2:0] c_OVER    = 3'd6;

    logic [2:0]      r_state;
    logic [c_CW-1:0] r_clr_cnt;
    logic            r_armed;
    logic            r_exp_first;
    logic            r_score;
    logic [3:0]      r_phase;
    logic [3:0]      r_lives;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_clr_cnt   <= '0;
            r_armed     <= 1'b0;
            r_exp_first <= 1'b0;
            r_score     <= 1'b0;
            r_phase     <= 4'd0;
            r_lives     <= c_LIVES;
        end else begin
            r_score <= 1'b0;
            case (r_state)
                c_IDLE, c_OVER: begin
                    if (start) begin
                        r_state   <= c_CLEAR;
                        r_clr_cnt <= '0;
                    end
                end
                c_CLEAR: begin
                    r_lives <= c_LIVES;
                    r_phase <= 4'd0;
                    r_armed <= 1'b0;
                    if (r_clr_cnt == c_CLR_LAST) r_state <= c_WAIT;
                    else r_clr_cnt <= r_clr_cnt + 1'b1;
                end
                c_WAIT, c_STEP: begin
                    if (timeUp) begin
                        r_state <= c_OVER;
                    end else if (collision) begin
                        if (r_lives <= 4'd1) begin
                            r_lives <= 4'd0;
                            r_state <= c_OVER;
                        end else begin
                            r_lives <= r_lives - 4'd1;
                            r_armed <= 1'b0;
                            r_state <= c_RECOVER;
                        end
                    end else if (runOver) begin
                        r_armed     <= 1'b0;
                        r_exp_first <= 1'b1;
                        r_state     <= c_EXPLODE;
                    end else if (r_state == c_WAIT) begin
                        // First expiry is the timer reload; the second one is real.
                        if (startCycle) begin
                            r_armed <= ~r_armed;
                            if (r_armed) r_state <= c_STEP;
                        end
                    end else if (changeState) begin
                        if (r_phase < c_LAST_PHASE) begin
                            r_phase <= r_phase + 4'd1;
                        end else begin
                            r_phase <= 4'd0;
                            r_score <= 1'b1;
                            r_armed <= 1'b0;
                            r_state <= c_WAIT;
                        end
                    end
                end
                c_RECOVER: begin
                    if (timeUp) begin
                        r_state <= c_OVER;
                    end else if (recover) begin
                        r_armed <= ~r_armed;
                        if (r_armed) begin
                            r_phase <= 4'd0;
                            r_state <= c_WAIT;
                        end
                    end
                end
                c_EXPLODE: begin
                    r_exp_first <= 1'b0;
                    if (timeUp) begin
                        r_state <= c_OVER;
                    end else if (!r_exp_first && explosionDone) begin
                        r_armed <= 1'b0;
                        r_state <= c_WAIT;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign CounterClear         = (r_state == c_IDLE) || (r_state == c_CLEAR) || (r_state == c_OVER);
    assign CycleWaitCounterEn   = (r_state == c_WAIT);
    assign ChangeStateCounterEn = (r_state == c_STEP);
    assign StartRecover         = (r_state == c_RECOVER);
    assign playing              = (r_state == c_WAIT) || (r_state == c_STEP);
    assign gameOver             = (r_state == c_OVER);
    assign ScoreInc             = r_score;
    assign obstaclePhase        = r_phase;
    assign lives                = r_lives;

endmodule
`default_nettype wire
